// File: rtl/decode_stage.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | decode_stage: instruction decode, operand fetch/forward, hazard scoreboard |
// | and condition-code gating. Optional DECODE_FWD_EN enables forwarding.      |
// | Revision: 1.0                                                              |
// +---------------------------------------------------------------------------+
module decode_stage #(
  parameter int NUM_FWD      = 2,
  parameter int MAX_INFLIGHT = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          instr_i,
  output logic [3:0]           ra_o,
  output logic [3:0]           rb_o,
  output logic [3:0]           rc_o,
  input  logic [31:0]          ra_i,
  input  logic [31:0]          rb_i,
  input  logic [31:0]          rc_i,
  input  logic [NUM_FWD-1:0]   fwd_valid_i,
  input  logic [4*NUM_FWD-1:0] fwd_dest_i,
  input  logic [32*NUM_FWD-1:0] fwd_data_i,
  input  logic                 wb_valid_i,
  input  logic [3:0]           wb_dest_i,
  input  logic                 flags_valid_i,
  input  logic [3:0]           flags_i,
  input  logic                 flush_i,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [1:0]           out_class,
  output logic [3:0]           out_opcode,
  output logic [31:0]          out_a,
  output logic [31:0]          out_b,
  output logic [31:0]          out_c,
  output logic [3:0]           out_dest,
  output logic                 out_exec,
  output logic                 out_wr_dest,
  output logic                 out_wr_flags,
  output logic                 out_acc
);
  localparam int             c_CNT_W     = $clog2(MAX_INFLIGHT + 1);
  localparam logic [c_CNT_W-1:0] c_MAX   = c_CNT_W'(MAX_INFLIGHT);
  localparam logic [1:0]     c_CLS_DP    = 2'd0;
  localparam logic [1:0]     c_CLS_MUL   = 2'd1;
  localparam logic [1:0]     c_CLS_NOP   = 2'd2;
  localparam logic [1:0]     c_CLS_UNDEF = 2'd3;

  typedef enum logic [1:0] {S_EMPTY = 2'd0, S_FULL = 2'd1, S_STALL = 2'd2} state_t;
  state_t r_state;

  logic [15:0]        r_pend;
  logic [c_CNT_W-1:0] r_flag_pend;
  logic [3:0]         r_cpsr;

  logic [1:0]  w_class;
  logic [3:0]  w_src_a, w_src_b, w_src_c, w_dest, w_opcode;
  logic        w_use_a, w_use_b, w_use_c, w_imm, w_wr_dest, w_wr_flags, w_acc;

  always_comb begin
    w_class = c_CLS_UNDEF;
    w_src_a = 4'd0; w_src_b = 4'd0; w_src_c = 4'd0;
    w_use_a = 1'b0; w_use_b = 1'b0; w_use_c = 1'b0;
    w_dest = 4'd0; w_opcode = 4'd0; w_imm = 1'b0; w_acc = 1'b0;
    w_wr_dest = 1'b0; w_wr_flags = 1'b0;
    if (instr_i[27:0] == 28'h320F000) begin
      w_class = c_CLS_NOP;
    end else if (!instr_i[25] && instr_i[7:4] == 4'b1001) begin
      w_class   = c_CLS_MUL;
      w_src_a   = instr_i[3:0];
      w_src_b   = instr_i[11:8];
      w_src_c   = instr_i[15:12];
      w_use_a   = 1'b1;
      w_use_b   = 1'b1;
      w_use_c   = instr_i[21];
      w_acc     = instr_i[21];
      w_dest    = instr_i[19:16];
      w_wr_dest = 1'b1;
      w_wr_flags = instr_i[20];
    end else if (instr_i[27:26] == 2'b00) begin
      w_class  = c_CLS_DP;
      w_src_a  = instr_i[19:16];
      w_src_b  = instr_i[3:0];
      w_use_a  = 1'b1;
      w_use_b  = !instr_i[25];
      w_imm    = instr_i[25];
      w_dest   = instr_i[15:12];
      w_opcode = instr_i[24:21];
      // TST/TEQ/CMP/CMN only update flags
      if (instr_i[24:23] == 2'b10) begin
        w_wr_dest  = 1'b0;
        w_wr_flags = 1'b1;
      end else begin
        w_wr_dest  = 1'b1;
        w_wr_flags = instr_i[20];
      end
    end
  end

  assign ra_o = rst ? 4'd0 : w_src_a;
  assign rb_o = rst ? 4'd0 : w_src_b;
  assign rc_o = rst ? 4'd0 : w_src_c;

  logic [31:0] w_val_a, w_val_b, w_val_c;
  logic        w_hit_a, w_hit_b, w_hit_c;
`ifdef DECODE_FWD_EN
  // Descending scan so the lowest-index matching port wins.
  always_comb begin
    w_val_a = ra_i; w_val_b = rb_i; w_val_c = rc_i;
    w_hit_a = 1'b0; w_hit_b = 1'b0; w_hit_c = 1'b0;
    for (int k = NUM_FWD - 1; k >= 0; k--) begin
      if (fwd_valid_i[k] && fwd_dest_i[4*k +: 4] == w_src_a) begin
        w_hit_a = 1'b1; w_val_a = fwd_data_i[32*k +: 32];
      end
      if (fwd_valid_i[k] && fwd_dest_i[4*k +: 4] == w_src_b) begin
        w_hit_b = 1'b1; w_val_b = fwd_data_i[32*k +: 32];
      end
      if (fwd_valid_i[k] && fwd_dest_i[4*k +: 4] == w_src_c) begin
        w_hit_c = 1'b1; w_val_c = fwd_data_i[32*k +: 32];
      end
    end
  end
`else
  logic w_unused_fwd;
  assign w_unused_fwd = ^{fwd_valid_i, fwd_dest_i, fwd_data_i};
  assign w_val_a = ra_i;
  assign w_val_b = rb_i;
  assign w_val_c = rc_i;
  assign w_hit_a = 1'b0;
  assign w_hit_b = 1'b0;
  assign w_hit_c = 1'b0;
`endif

  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n, z, c, v;
    {n, z, c, v} = nzcv;
    case (cond)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return c;
      4'h3: return !c;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return c && !z;
      4'h9: return !c || z;
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  logic w_exec, w_hazard, w_cond_stall, w_full_stall, w_stall, w_accept, w_kill;
  assign w_exec = cond_pass(instr_i[31:28], r_cpsr) &&
                  (w_class == c_CLS_DP || w_class == c_CLS_MUL);
  assign w_hazard = (w_use_a && r_pend[w_src_a] && !w_hit_a) ||
                    (w_use_b && r_pend[w_src_b] && !w_hit_b) ||
                    (w_use_c && r_pend[w_src_c] && !w_hit_c);
  assign w_cond_stall = (instr_i[31:28] != 4'hE) && (r_flag_pend != '0);
  assign w_full_stall = w_wr_flags && (r_flag_pend == c_MAX);
  assign w_stall      = w_hazard || w_cond_stall || w_full_stall;
  assign in_ready     = !rst && (!out_valid || out_ready) && !w_stall && !flush_i;
  assign w_accept     = in_valid && in_ready;
  assign w_kill       = flush_i && out_valid;

  logic [15:0]        w_sb_set, w_sb_clr;
  logic [c_CNT_W-1:0] w_fp_next;
  always_comb begin
    w_sb_set = '0;
    w_sb_clr = '0;
    if (w_accept && w_exec && w_wr_dest) w_sb_set[w_dest] = 1'b1;
    if (wb_valid_i) w_sb_clr[wb_dest_i] = 1'b1;
    if (w_kill && out_exec && out_wr_dest) w_sb_clr[out_dest] = 1'b1;
    w_fp_next = r_flag_pend;
    if (w_accept && w_exec && w_wr_flags) w_fp_next = w_fp_next + c_CNT_W'(1);
    if (flags_valid_i && w_fp_next != '0) w_fp_next = w_fp_next - c_CNT_W'(1);
    if (w_kill && out_exec && out_wr_flags && w_fp_next != '0)
      w_fp_next = w_fp_next - c_CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend      <= '0;
      r_flag_pend <= '0;
      r_cpsr      <= 4'd0;
    end else begin
      r_pend      <= (r_pend & ~w_sb_clr) | w_sb_set;
      r_flag_pend <= w_fp_next;
      if (flags_valid_i) r_cpsr <= flags_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_EMPTY;
      out_valid    <= 1'b0;
      out_class    <= 2'd0;
      out_opcode   <= 4'd0;
      out_a        <= 32'd0;
      out_b        <= 32'd0;
      out_c        <= 32'd0;
      out_dest     <= 4'd0;
      out_exec     <= 1'b0;
      out_wr_dest  <= 1'b0;
      out_wr_flags <= 1'b0;
      out_acc      <= 1'b0;
    end else begin
      if (w_accept) begin
        out_valid    <= 1'b1;
        out_class    <= w_class;
        out_opcode   <= w_opcode;
        out_a        <= w_val_a;
        out_b        <= w_imm ? {20'd0, instr_i[11:0]} : w_val_b;
        out_c        <= w_val_c;
        out_dest     <= w_dest;
        out_exec     <= w_exec;
        out_wr_dest  <= w_wr_dest;
        out_wr_flags <= w_wr_flags;
        out_acc      <= w_acc;
      end else if (flush_i || out_ready) begin
        out_valid <= 1'b0;
      end
      if (in_valid && w_stall) begin
        r_state <= S_STALL;
      end else begin
        case (r_state)
          S_EMPTY: r_state <= w_accept ? S_FULL : S_EMPTY;
          S_FULL: begin
            if (w_accept)                  r_state <= S_FULL;
            else if (out_ready || flush_i) r_state <= S_EMPTY;
          end
          default: r_state <= (w_accept || (out_valid && !out_ready && !flush_i))
                              ? S_FULL : S_EMPTY;
        endcase
      end
    end
  end
endmodule
`default_nettype wire
